osd_mam_sram_adapter: RTL and testbench

Downstream stage of the memory access module (MAM). It terminates the MAM request/write/read handshake port and drives a single-port synchronous SRAM with 1-cycle read latency. The block handles address translation, burst sequencing, byte strobes and read backpressure, so a plain SRAM macro can serve as a debug-accessible memory region.

---
 rtl/osd_mam_pkg.sv | 36 +++
 rtl/osd_mam_sram_rbuf.sv | 58 +++++
 rtl/osd_mam_sram_adapter.sv | 191 +++++++++++++++++++
 tb/tb_osd_mam_sram_adapter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osd_mam_pkg.sv
// Shared MAM request definitions: field widths, rw encodings and the
// adapter FSM state type. The MAM front end reuses the same package.
package osd_mam_pkg;

    localparam int BEATS_WIDTH = 14;

    localparam logic MAM_READ  = 1'b0;
    localparam logic MAM_WRITE = 1'b1;

    localparam logic [BEATS_WIDTH-1:0] BEATS_ZERO = 14'd0;
    localparam logic [BEATS_WIDTH-1:0] BEATS_ONE  = 14'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } sram_state_e;

    // Number of words a request moves: single beats are always one word,
    // and a zero-length burst still transfers one word.
    function automatic logic [BEATS_WIDTH-1:0] beat_count(
        input logic                   burst,
        input logic [BEATS_WIDTH-1:0] beats
    );
        logic [BEATS_WIDTH-1:0] n;
        if (!burst) begin
            n = BEATS_ONE;
        end else if (beats == BEATS_ZERO) begin
            n = BEATS_ONE;
        end else begin
            n = beats;
        end
        return n;
    endfunction

endpackage

// File: rtl/osd_mam_sram_rbuf.sv
// Two-entry valid/ready FIFO that holds SRAM read data until the MAM side
// accepts it. Push and pop may happen in the same cycle at any fill level.
module osd_mam_sram_rbuf #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_valid,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [1:0]            fill
);

    logic [DATA_WIDTH-1:0] entry_r [2];
    logic                  rd_ptr_r;
    logic                  wr_ptr_r;
    logic [1:0]            count_r;
    logic                  pop_s;
    logic                  push_s;

    assign out_valid = (count_r != 2'd0);
    assign out_data  = entry_r[rd_ptr_r];
    assign fill      = count_r;
    assign pop_s     = out_valid && out_ready;
    // A full buffer can still take a word when the head leaves this cycle.
    assign push_s    = push_valid && ((count_r != 2'd2) || pop_s);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Data storage; contents are only meaningful while counted as valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            entry_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/osd_mam_sram_adapter.sv
// Terminates the MAM request/write/read port and drives a single-port
// synchronous SRAM with one cycle of read latency. Handles base-address
// translation, burst address sequencing with wrap, byte strobes and read
// backpressure through a two-entry output buffer.
module osd_mam_sram_adapter
    import osd_mam_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_rw,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    input  logic                         req_burst,
    input  logic [BEATS_WIDTH-1:0]       req_beats,
    input  logic                         write_valid,
    input  logic [DATA_WIDTH-1:0]        write_data,
    input  logic [DATA_WIDTH/8-1:0]      write_strb,
    output logic                         write_ready,
    output logic                         read_valid,
    output logic [DATA_WIDTH-1:0]        read_data,
    input  logic                         read_ready,
    output logic                         sram_ce,
    output logic                         sram_we,
    output logic [$clog2(MEM_WORDS)-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0]        sram_wdata,
    output logic [DATA_WIDTH/8-1:0]      sram_wmask,
    input  logic [DATA_WIDTH-1:0]        sram_rdata
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int MAW    = $clog2(MEM_WORDS);
    localparam int OFFS   = $clog2(STRB_W);

    localparam logic [MAW-1:0] ADDR_ONE = {{(MAW-1){1'b0}}, 1'b1};

    sram_state_e            state_r;
    sram_state_e            state_s;
    logic [MAW-1:0]         addr_r;
    logic [BEATS_WIDTH-1:0] remain_r;
    logic                   burst_r;
    logic                   in_flight_r;

    logic [ADDR_WIDTH-1:0]  offset_s;
    logic [ADDR_WIDTH-1:0]  shifted_s;
    logic [MAW-1:0]         start_addr_s;
    logic                   unused_addr_bits_s;
    logic                   req_fire_s;
    logic                   wr_fire_s;
    logic                   issue_s;
    logic                   pop_s;
    logic [2:0]             outstanding_s;
    logic                   buf_valid_s;
    logic [DATA_WIDTH-1:0]  buf_data_s;
    logic [1:0]             fill_s;

    // Byte address relative to the window, reduced to a word index. The low
    // byte-offset bits and anything above the SRAM depth are discarded.
    assign offset_s           = req_addr - BASE_ADDR;
    assign shifted_s          = offset_s >> OFFS;
    assign start_addr_s       = shifted_s[MAW-1:0];
    assign unused_addr_bits_s = ^offset_s;

    assign req_fire_s = (state_r == ST_IDLE) && rst && req_valid;
    assign wr_fire_s  = (state_r == ST_WRITE) && rst && write_valid;

    // Read side: a word is outstanding from issue until it leaves the buffer.
    assign read_valid    = buf_valid_s && rst;
    assign read_data     = buf_data_s;
    assign pop_s         = read_valid && read_ready;
    assign outstanding_s = {1'b0, fill_s} + {2'b00, in_flight_r} - {2'b00, pop_s};
    assign issue_s       = (state_r == ST_READ) && rst && (remain_r != BEATS_ZERO)
                           && (outstanding_s < 3'd2);

    assign sram_addr = addr_r;

    osd_mam_sram_rbuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rbuf (
        .clk        (clk),
        .rst        (rst),
        .push_valid (in_flight_r),
        .push_data  (sram_rdata),
        .out_valid  (buf_valid_s),
        .out_data   (buf_data_s),
        .out_ready  (read_ready),
        .fill       (fill_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_s = (req_rw == MAM_WRITE) ? ST_WRITE : ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (wr_fire_s && (remain_r == BEATS_ONE)) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_READ: begin
                // Leave on the cycle the final word is popped.
                if ((remain_r == BEATS_ZERO) && !in_flight_r &&
                    ((fill_s == 2'd0) || ((fill_s == 2'd1) && pop_s))) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_READ;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output decode; everything handshake-related is held low in reset.
    always_comb begin
        req_ready   = 1'b0;
        write_ready = 1'b0;
        sram_ce     = 1'b0;
        sram_we     = 1'b0;
        sram_wdata  = '0;
        sram_wmask  = '0;
        case (state_r)
            ST_IDLE: begin
                req_ready = rst;
            end
            ST_WRITE: begin
                write_ready = rst;
                if (wr_fire_s) begin
                    sram_ce    = 1'b1;
                    sram_we    = 1'b1;
                    sram_wdata = write_data;
                    sram_wmask = burst_r ? {STRB_W{1'b1}} : write_strb;
                end else begin
                    sram_ce    = 1'b0;
                    sram_we    = 1'b0;
                end
            end
            ST_READ: begin
                sram_ce = issue_s;
            end
            default: begin
                sram_ce = 1'b0;
            end
        endcase
    end

    // Request latch, word address sequencing and in-flight read tracking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_r      <= '0;
            remain_r    <= BEATS_ZERO;
            burst_r     <= 1'b0;
            in_flight_r <= 1'b0;
        end else begin
            in_flight_r <= issue_s;
            if (req_fire_s) begin
                addr_r   <= start_addr_s;
                remain_r <= beat_count(req_burst, req_beats);
                burst_r  <= req_burst;
            end else if (wr_fire_s || issue_s) begin
                addr_r   <= addr_r + ADDR_ONE;
                remain_r <= remain_r - BEATS_ONE;
            end else begin
                addr_r   <= addr_r;
                remain_r <= remain_r;
            end
        end
    end

endmodule

// File: tb/tb_osd_mam_sram_adapter.sv
// Directed bench for osd_mam_sram_adapter with a behavioural 1-cycle SRAM.
module tb_osd_mam_sram_adapter;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int MW  = 16;
    localparam int SW  = 4;
    localparam int MAW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic           req_rw;
    logic [AW-1:0]  req_addr;
    logic           req_burst;
    logic [13:0]    req_beats;
    logic           write_valid;
    logic [DW-1:0]  write_data;
    logic [SW-1:0]  write_strb;
    logic           write_ready;
    logic           read_valid;
    logic [DW-1:0]  read_data;
    logic           read_ready;
    logic           sram_ce;
    logic           sram_we;
    logic [MAW-1:0] sram_addr;
    logic [DW-1:0]  sram_wdata;
    logic [SW-1:0]  sram_wmask;
    logic [DW-1:0]  sram_rdata;

    logic [DW-1:0]  mem [MW];
    int             wr_count = 0;
    logic           pl_en = 1'b0;
    logic [MAW-1:0] pl_addr = 4'd0;
    logic [DW-1:0]  pl_data = 32'd0;

    int n_cmp = 0;
    int n_bad = 0;

    osd_mam_sram_adapter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MEM_WORDS  (MW),
        .BASE_ADDR  (32'h0000_1000)
    ) dut (
        .clk (clk), .rst (rst),
        .req_valid (req_valid), .req_ready (req_ready), .req_rw (req_rw),
        .req_addr (req_addr), .req_burst (req_burst), .req_beats (req_beats),
        .write_valid (write_valid), .write_data (write_data),
        .write_strb (write_strb), .write_ready (write_ready),
        .read_valid (read_valid), .read_data (read_data), .read_ready (read_ready),
        .sram_ce (sram_ce), .sram_we (sram_we), .sram_addr (sram_addr),
        .sram_wdata (sram_wdata), .sram_wmask (sram_wmask), .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model: byte-masked writes, registered reads, plus a preload port.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (sram_ce && sram_we) begin
            for (int b = 0; b < SW; b++) begin
                if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
            wr_count <= wr_count + 1;
        end else if (sram_ce) begin
            sram_rdata <= mem[sram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [MAW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h0;
        req_burst = 1'b0; req_beats = 14'd0; write_valid = 1'b1;
        write_data = 32'h0; write_strb = 4'h0; read_ready = 1'b0;
        tick(); tick(); #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        n_cmp++; if (write_ready !== 1'b0) begin n_bad++; $display("FAIL reset_write_ready: got %b want 0", write_ready); end
        n_cmp++; if (read_valid !== 1'b0) begin n_bad++; $display("FAIL reset_read_valid: got %b want 0", read_valid); end
        n_cmp++; if (sram_ce !== 1'b0) begin n_bad++; $display("FAIL reset_sram_ce: got %b want 0", sram_ce); end
        n_cmp++; if (sram_we !== 1'b0) begin n_bad++; $display("FAIL reset_sram_we: got %b want 0", sram_we); end
        req_valid = 1'b0; write_valid = 1'b0; rst = 1'b1;
        tick(); #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL idle_req_ready: got %b want 1", req_ready); end
        n_cmp++; if (sram_ce !== 1'b0) begin n_bad++; $display("FAIL idle_sram_ce: got %b want 0", sram_ce); end
    endtask

    task automatic test_single_write();
        int wc0;
        preload(4'd2, 32'h1122_3344);
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 32'h0000_1008; req_burst = 1'b0; req_beats = 14'd5;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL sw_req_ready: got %b want 1", req_ready); end
        tick();
        req_valid = 1'b0; write_valid = 1'b1; write_data = 32'hAABB_CCDD; write_strb = 4'b0101;
        wc0 = wr_count;
        #1;
        n_cmp++; if (write_ready !== 1'b1) begin n_bad++; $display("FAIL sw_write_ready: got %b want 1", write_ready); end
        n_cmp++; if ({sram_ce, sram_we} !== 2'b11) begin n_bad++; $display("FAIL sw_ce_we: got %b want 11", {sram_ce, sram_we}); end
        n_cmp++; if (sram_addr !== 4'd2) begin n_bad++; $display("FAIL sw_addr: got %0d want 2", sram_addr); end
        n_cmp++; if (sram_wmask !== 4'b0101) begin n_bad++; $display("FAIL sw_wmask: got %b want 0101", sram_wmask); end
        n_cmp++; if (sram_wdata !== 32'hAABB_CCDD) begin n_bad++; $display("FAIL sw_wdata: got %h want aabbccdd", sram_wdata); end
        tick();
        write_valid = 1'b0;
        #1;
        n_cmp++; if (write_ready !== 1'b0) begin n_bad++; $display("FAIL sw_write_ready_drop: got %b want 0", write_ready); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL sw_back_idle: got %b want 1", req_ready); end
        n_cmp++; if (mem[2] !== 32'h11BB_33DD) begin n_bad++; $display("FAIL sw_mem2: got %h want 11bb33dd", mem[2]); end
        n_cmp++; if (wr_count - wc0 !== 1) begin n_bad++; $display("FAIL sw_count: got %0d want 1", wr_count - wc0); end
    endtask

    task automatic test_burst_read();
        for (int i = 0; i < 8; i++) preload(i[3:0], DW'(i));
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h0000_1000; req_burst = 1'b1;
        req_beats = 14'd8; read_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            #1;
            if (k == 1) begin
                n_cmp++; if ({sram_ce, sram_we} !== 2'b10) begin n_bad++; $display("FAIL br_first_issue: got %b want 10", {sram_ce, sram_we}); end
            end
            n_cmp++;
            if (read_valid !== ((k >= 3) && (k <= 10))) begin
                n_bad++; $display("FAIL br_valid_c%0d: got %b want %b", k, read_valid, ((k >= 3) && (k <= 10)));
            end
            if ((k >= 3) && (k <= 10)) begin
                n_cmp++; if (read_data !== DW'(k - 3)) begin n_bad++; $display("FAIL br_data_c%0d: got %h want %h", k, read_data, DW'(k - 3)); end
            end
            if (k == 11) begin
                n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL br_req_ready_after: got %b want 1", req_ready); end
            end
            tick();
        end
        read_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int issued = 0, popped = 0, ngot = 0;
        bit done = 1'b0;
        logic pop;
        for (int i = 4; i < 10; i++) preload(i[3:0], 32'hA0 + DW'(i));
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h0000_1010; req_burst = 1'b1; req_beats = 14'd6;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 60 && !done; k++) begin
            read_ready = ((k - 1) % 3 == 0);
            #1;
            pop = read_valid && read_ready;
            if ((issued - popped - int'(pop)) >= 2) begin
                n_cmp++; if (sram_ce !== 1'b0) begin n_bad++; $display("FAIL bp_stall_c%0d: ce got %b want 0", k, sram_ce); end
            end
            if (sram_ce && !sram_we) issued++;
            if (pop) begin
                n_cmp++;
                if (read_data !== 32'hA4 + DW'(ngot)) begin n_bad++; $display("FAIL bp_data_%0d: got %h want %h", ngot, read_data, 32'hA4 + DW'(ngot)); end
                ngot++; popped++;
            end
            tick();
            if (req_ready && ngot == 6) done = 1'b1;
        end
        read_ready = 1'b0;
        n_cmp++; if (!done) begin n_bad++; $display("FAIL bp_timeout: got %0d words want 6", ngot); end
        n_cmp++; if (issued !== 6) begin n_bad++; $display("FAIL bp_issued: got %0d want 6", issued); end
        #1;
        n_cmp++; if (read_valid !== 1'b0) begin n_bad++; $display("FAIL bp_extra_valid: got %b want 0", read_valid); end
    endtask

    task automatic test_wrap();
        int wc0;
        preload(4'd14, 32'h0); preload(4'd15, 32'h0); preload(4'd0, 32'h0);
        preload(4'd1, 32'h0); preload(4'd2, 32'h0);
        wc0 = wr_count;
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 32'h0000_1038; req_burst = 1'b1; req_beats = 14'd4;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            write_valid = 1'b1; write_data = 32'hC0DE_0000 + DW'(i); write_strb = 4'b0001;
            #1;
            n_cmp++; if (sram_addr !== 4'((14 + i) % 16)) begin n_bad++; $display("FAIL wr_addr_%0d: got %0d want %0d", i, sram_addr, (14 + i) % 16); end
            n_cmp++; if (sram_wmask !== 4'hF) begin n_bad++; $display("FAIL wr_mask_%0d: got %b want 1111", i, sram_wmask); end
            tick();
        end
        write_valid = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL wr_back_idle: got %b want 1", req_ready); end
        n_cmp++; if (mem[14] !== 32'hC0DE_0000) begin n_bad++; $display("FAIL wr_mem14: got %h want c0de0000", mem[14]); end
        n_cmp++; if (mem[15] !== 32'hC0DE_0001) begin n_bad++; $display("FAIL wr_mem15: got %h want c0de0001", mem[15]); end
        n_cmp++; if (mem[0] !== 32'hC0DE_0002) begin n_bad++; $display("FAIL wr_mem0: got %h want c0de0002", mem[0]); end
        n_cmp++; if (mem[1] !== 32'hC0DE_0003) begin n_bad++; $display("FAIL wr_mem1: got %h want c0de0003", mem[1]); end
        n_cmp++; if (mem[2] !== 32'h0) begin n_bad++; $display("FAIL wr_mem2_untouched: got %h want 0", mem[2]); end
        n_cmp++; if (wr_count - wc0 !== 4) begin n_bad++; $display("FAIL wr_count: got %0d want 4", wr_count - wc0); end
    endtask

    task automatic test_gaps_zero();
        int wc0;
        preload(4'd5, 32'h0); preload(4'd8, 32'h0); preload(4'd9, 32'h0);
        preload(4'd10, 32'h0); preload(4'd11, 32'h0);
        wc0 = wr_count;
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 32'h0000_1014; req_burst = 1'b1; req_beats = 14'd0;
        tick();
        req_valid = 1'b0; write_valid = 1'b1; write_data = 32'h1234_5678; write_strb = 4'b0000;
        #1;
        n_cmp++; if ({sram_ce, sram_wmask} !== 5'b1_1111) begin n_bad++; $display("FAIL z_ce_mask: got %b want 11111", {sram_ce, sram_wmask}); end
        tick();
        write_data = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if ({req_ready, write_ready, sram_ce} !== 3'b100) begin n_bad++; $display("FAIL z_one_beat: got %b want 100", {req_ready, write_ready, sram_ce}); end
        n_cmp++; if (wr_count - wc0 !== 1) begin n_bad++; $display("FAIL z_count: got %0d want 1", wr_count - wc0); end
        n_cmp++; if (mem[5] !== 32'h1234_5678) begin n_bad++; $display("FAIL z_mem5: got %h want 12345678", mem[5]); end
        write_valid = 1'b0;
        wc0 = wr_count;
        req_valid = 1'b1; req_addr = 32'h0000_1020; req_beats = 14'd3;
        tick();
        req_valid = 1'b0;
        for (int j = 0; j < 7; j++) begin
            write_valid = (j % 3 == 0);
            write_data = 32'h0B00_0000 + DW'(j / 3);
            #1;
            n_cmp++; if (write_ready !== 1'b1) begin n_bad++; $display("FAIL g_ready_%0d: got %b want 1", j, write_ready); end
            tick();
        end
        write_valid = 1'b1; write_data = 32'hFFFF_FFFF;
        #1;
        n_cmp++; if ({req_ready, sram_ce} !== 2'b10) begin n_bad++; $display("FAIL g_idle: got %b want 10", {req_ready, sram_ce}); end
        tick();
        write_valid = 1'b0;
        n_cmp++; if (wr_count - wc0 !== 3) begin n_bad++; $display("FAIL g_count: got %0d want 3", wr_count - wc0); end
        n_cmp++; if (mem[8] !== 32'h0B00_0000) begin n_bad++; $display("FAIL g_mem8: got %h want 0b000000", mem[8]); end
        n_cmp++; if (mem[10] !== 32'h0B00_0002) begin n_bad++; $display("FAIL g_mem10: got %h want 0b000002", mem[10]); end
        n_cmp++; if (mem[11] !== 32'h0) begin n_bad++; $display("FAIL g_mem11: got %h want 0", mem[11]); end
    endtask

    task automatic test_reset_mid_read();
        int pops = 0, n = 0;
        for (int i = 0; i < 10; i++) preload(i[3:0], 32'h50 + DW'(i));
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h0000_1000; req_burst = 1'b1;
        req_beats = 14'd10; read_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 20 && pops < 3; k++) begin
            #1;
            if (read_valid) begin
                n_cmp++; if (read_data !== 32'h50 + DW'(pops)) begin n_bad++; $display("FAIL rr_data_%0d: got %h want %h", pops, read_data, 32'h50 + DW'(pops)); end
                pops++;
            end
            tick();
        end
        rst = 1'b0;
        tick(); #1;
        n_cmp++; if ({read_valid, sram_ce, req_ready} !== 3'b000) begin n_bad++; $display("FAIL rr_in_reset: got %b want 000", {read_valid, sram_ce, req_ready}); end
        rst = 1'b1;
        tick(); #1;
        n_cmp++; if ({req_ready, read_valid} !== 2'b10) begin n_bad++; $display("FAIL rr_after_reset: got %b want 10", {req_ready, read_valid}); end
        preload(4'd0, 32'h90); preload(4'd1, 32'h91);
        req_valid = 1'b1; req_beats = 14'd2;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            if (read_valid) begin
                n_cmp++; if (read_data !== 32'h90 + DW'(n)) begin n_bad++; $display("FAIL rr_fresh_%0d: got %h want %h", n, read_data, 32'h90 + DW'(n)); end
                n++;
            end
            tick();
        end
        n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL rr_fresh_count: got %0d want 2", n); end
        read_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_read();
        test_backpressure();
        test_wrap();
        test_gaps_zero();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
